// File: rtl/sad_search_engine_if.sv
// Handshake and result bus between the memory stage and the SAD search engine.
// master: row-vector source / result consumer; slave: the engine itself.
// Widths follow the same parameters as the engine so both sides agree on SAD_W.
interface sad_search_engine_if #(
  parameter int PIX_W   = 8,
  parameter int LANES   = 4,
  parameter int ROWS    = 4,
  parameter int COORD_W = 6
);
  localparam int SAD_W = PIX_W + $clog2(LANES * ROWS);

  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*PIX_W-1:0]   frame_vec;
  logic [LANES*PIX_W-1:0]   win_vec;
  logic [COORD_W-1:0]       in_x;
  logic [COORD_W-1:0]       in_y;
  logic                     in_last_cand;
  logic                     sad_valid;
  logic [SAD_W-1:0]         sad_value;
  logic [COORD_W-1:0]       sad_x;
  logic [COORD_W-1:0]       sad_y;
  logic [SAD_W-1:0]         min_sad;
  logic [COORD_W-1:0]       min_x;
  logic [COORD_W-1:0]       min_y;
  logic                     min_valid;
  logic                     search_done;
  logic                     busy;

  modport master (
    output start, in_valid, frame_vec, win_vec, in_x, in_y, in_last_cand,
    input  in_ready, sad_valid, sad_value, sad_x, sad_y,
           min_sad, min_x, min_y, min_valid, search_done, busy
  );

  modport slave (
    input  start, in_valid, frame_vec, win_vec, in_x, in_y, in_last_cand,
    output in_ready, sad_valid, sad_value, sad_x, sad_y,
           min_sad, min_x, min_y, min_valid, search_done, busy
  );
endinterface

// File: rtl/sad_search_engine.sv
// Pipelined block-match SAD engine: per-candidate SAD stream plus running minimum and its (X,Y).
// Latency: SAD out 2 cycles after the last-row beat; minimum updated one cycle later.
// Backpressure: in_ready is high only in RUN; no stalls inside RUN, beats may arrive at full rate.
module sad_search_engine #(
  parameter int PIX_W   = 8,
  parameter int LANES   = 4,
  parameter int ROWS    = 4,
  parameter int COORD_W = 6
) (
  input logic                clk,
  input logic                rst,
  sad_search_engine_if.slave bus
);
  localparam int SAD_W = PIX_W + $clog2(LANES * ROWS);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         drain_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic               accept;
  logic               row_last;
  logic               row_first;
  logic               start_ok;

  // stage 1: per-lane absolute differences
  logic [PIX_W-1:0]   lane_diff [LANES];
  logic [PIX_W-1:0]   s1_diff   [LANES];
  logic               s1_valid;
  logic               s1_first;
  logic               s1_last;
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;

  // stage 2: row sum accumulation
  logic [SAD_W-1:0]   lane_sum;
  logic [SAD_W-1:0]   acc;
  logic               s2_last;
  logic [COORD_W-1:0] s2_x;
  logic [COORD_W-1:0] s2_y;

  assign start_ok  = (state == IDLE) && bus.start;
  assign accept    = (state == RUN) && bus.in_valid;
  assign row_last  = (row_cnt == LAST_ROW);
  assign row_first = (row_cnt == '0);

  assign bus.in_ready    = (state == RUN);
  assign bus.busy        = (state != IDLE);
  assign bus.search_done = (state == DONE);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: the final candidate's last row closes the search
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (accept && row_last && bus.in_last_cand) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // drain timer: 3 cycles lets the last SAD reach the minimum registers before done
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 drain_cnt <= '0;
    else if (state != DRAIN) drain_cnt <= '0;
    else                     drain_cnt <= drain_cnt + 2'd1;
  end

  // row counter: advances per accepted beat, wraps at the block height
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           row_cnt <= '0;
    else if (start_ok) row_cnt <= '0;
    else if (accept)   row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
  end

  // unsigned |frame - window| per lane
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_diff[i] = (bus.frame_vec[i*PIX_W +: PIX_W] >= bus.win_vec[i*PIX_W +: PIX_W])
                   ? bus.frame_vec[i*PIX_W +: PIX_W] - bus.win_vec[i*PIX_W +: PIX_W]
                   : bus.win_vec[i*PIX_W +: PIX_W] - bus.frame_vec[i*PIX_W +: PIX_W];
    end
  end

  // stage 1 registers; coordinates are captured on row 0 only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) s1_diff[i] <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) s1_diff[i] <= lane_diff[i];
        s1_first <= row_first;
        s1_last  <= row_last;
        if (row_first) begin
          s1_x <= bus.in_x;
          s1_y <= bus.in_y;
        end
      end
    end
  end

  // sum of the lane differences for the row held in stage 1
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + SAD_W'(s1_diff[i]);
  end

  // stage 2: row 0 loads the accumulator so candidates never bleed into each other
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      s2_last <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
    end else begin
      s2_last <= s1_valid && s1_last;
      if (start_ok) begin
        acc <= '0;
      end else if (s1_valid) begin
        acc <= s1_first ? lane_sum : acc + lane_sum;
        if (s1_first) begin
          s2_x <= s1_x;
          s2_y <= s1_y;
        end
      end
    end
  end

  // result stage: one pulse per completed candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sad_valid <= 1'b0;
      bus.sad_value <= '0;
      bus.sad_x     <= '0;
      bus.sad_y     <= '0;
    end else begin
      bus.sad_valid <= s2_last;
      if (s2_last) begin
        bus.sad_value <= acc;
        bus.sad_x     <= s2_x;
        bus.sad_y     <= s2_y;
      end
    end
  end

  // running minimum; strict compare so ties keep the earlier candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.min_sad   <= '1;
      bus.min_x     <= '0;
      bus.min_y     <= '0;
      bus.min_valid <= 1'b0;
    end else if (start_ok) begin
      bus.min_sad   <= '1;
      bus.min_x     <= '0;
      bus.min_y     <= '0;
      bus.min_valid <= 1'b0;
    end else if (bus.sad_valid && (!bus.min_valid || bus.sad_value < bus.min_sad)) begin
      bus.min_sad   <= bus.sad_value;
      bus.min_x     <= bus.sad_x;
      bus.min_y     <= bus.sad_y;
      bus.min_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sad_search_engine.sv
// Bench for sad_search_engine: directed scenarios with literal expectations plus randomized searches,
// all checked every cycle against a candidate-level model (SAD from pixel arrays, min from the SAD list).
module tb_sad_search_engine;
  localparam int PIX_W   = 8;
  localparam int LANES   = 4;
  localparam int ROWS    = 4;
  localparam int COORD_W = 6;
  localparam int SAD_W   = PIX_W + $clog2(LANES * ROWS);
  localparam int SAD_ONES = (1 << SAD_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sad_search_engine_if #(.PIX_W(PIX_W), .LANES(LANES), .ROWS(ROWS), .COORD_W(COORD_W)) bus ();

  sad_search_engine #(.PIX_W(PIX_W), .LANES(LANES), .ROWS(ROWS), .COORD_W(COORD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int sad;
    int x;
    int y;
    int due;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   obs_q[$];
  bit   pend = 1'b0;
  exp_t pend_e;
  int   m_sad = SAD_ONES;
  int   m_x = 0;
  int   m_y = 0;
  int   m_vld = 0;
  int   done_cyc = -10;
  int   cf[ROWS][LANES];
  int   cw[ROWS][LANES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int model_sad();
    int s = 0;
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++)
        s += (cf[r][l] > cw[r][l]) ? cf[r][l] - cw[r][l] : cw[r][l] - cf[r][l];
    return s;
  endfunction

  task automatic clear_px();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) begin
        cf[r][l] = 0;
        cw[r][l] = 0;
      end
  endtask

  task automatic fill_word(input logic [31:0] f, input logic [31:0] w);
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) begin
        cf[r][l] = int'((f >> (8 * l)) & 32'hFF);
        cw[r][l] = int'((w >> (8 * l)) & 32'hFF);
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) begin
        cf[r][l] = int'($urandom_range(0, 255));
        cw[r][l] = int'($urandom_range(0, 255));
      end
  endtask

  // Every cycle: SAD pulses at their due cycle, minimum from the SAD list, done at its due cycle.
  always @(negedge clk) begin
    #2;
    if (pend && pend_e.due == cyc) begin
      if (m_vld == 0 || pend_e.sad < m_sad) begin
        m_sad = pend_e.sad;
        m_x   = pend_e.x;
        m_y   = pend_e.y;
      end
      m_vld = 1;
      pend  = 1'b0;
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("sad_valid", int'(bus.sad_valid), 1);
      chk("sad_value", int'(bus.sad_value), exp_q[0].sad);
      chk("sad_x", int'(bus.sad_x), exp_q[0].x);
      chk("sad_y", int'(bus.sad_y), exp_q[0].y);
      pend_e     = exp_q.pop_front();
      pend_e.due = cyc + 1;
      pend       = 1'b1;
    end else begin
      chk("sad_valid_idle", int'(bus.sad_valid), 0);
    end
    if (bus.sad_valid) obs_q.push_back(int'(bus.sad_value));
    chk("min_sad", int'(bus.min_sad), m_sad);
    chk("min_x", int'(bus.min_x), m_x);
    chk("min_y", int'(bus.min_y), m_y);
    chk("min_valid", int'(bus.min_valid), m_vld);
    chk("search_done", int'(bus.search_done), (cyc == done_cyc) ? 1 : 0);
  end

  task automatic reset_model();
    exp_q.delete();
    pend     = 1'b0;
    m_sad    = SAD_ONES;
    m_x      = 0;
    m_y      = 0;
    m_vld    = 0;
    done_cyc = -10;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    bit idle;
    @(negedge clk);
    idle      = !bus.busy;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (idle) begin
      m_sad = SAD_ONES;
      m_x   = 0;
      m_y   = 0;
      m_vld = 0;
    end
  endtask

  // Sends nrows beats of the candidate held in cf/cw, with gap bubble cycles after each beat.
  task automatic send_cand(input int x, input int y, input bit last, input int gap, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      int waits = 0;
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.in_x         = COORD_W'(x);
      bus.in_y         = COORD_W'(y);
      bus.in_last_cand = last;
      for (int l = 0; l < LANES; l++) begin
        bus.frame_vec[l*PIX_W +: PIX_W] = PIX_W'(cf[r][l]);
        bus.win_vec[l*PIX_W +: PIX_W]   = PIX_W'(cw[r][l]);
      end
      while (!bus.in_ready && waits < 10) begin
        @(negedge clk);
        waits++;
      end
      chk("in_ready_beat", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (r == ROWS - 1) begin
        exp_q.push_back('{model_sad(), x, y, cyc + 2});
        if (last) done_cyc = cyc + 3;
      end
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    repeat (8) @(negedge clk);
    #1;
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  task automatic chk_obs(input string name, input int idx, input int expv);
    if (idx < obs_q.size()) chk(name, obs_q[idx], expv);
    else                    chk(name, -1, expv);
  endtask

  // The three-candidate 40/12/12 search used with and without bubbles.
  task automatic three_cands(input int gap);
    do_start();
    obs_q.delete();
    clear_px(); cf[0][0] = 40;
    send_cand(1, 0, 1'b0, gap, ROWS);
    clear_px(); cf[1][2] = 5; cw[3][1] = 7;
    send_cand(2, 0, 1'b0, gap, ROWS);
    clear_px(); cw[2][3] = 12;
    send_cand(3, 0, 1'b1, gap, ROWS);
    wait_idle();
    chk("three_count", obs_q.size(), 3);
    chk_obs("three_sad0", 0, 40);
    chk_obs("three_sad1", 1, 12);
    chk_obs("three_sad2", 2, 12);
    chk("three_min_sad", int'(bus.min_sad), 12);
    chk("three_min_x", int'(bus.min_x), 2);
    chk("three_min_y", int'(bus.min_y), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.frame_vec    = '0;
    bus.win_vec      = '0;
    bus.in_x         = '0;
    bus.in_y         = '0;
    bus.in_last_cand = 1'b0;
    clear_px();

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_min_sad", int'(bus.min_sad), 32'hFFF);
    chk("rst_min_x", int'(bus.min_x), 0);
    chk("rst_min_y", int'(bus.min_y), 0);
    chk("rst_sad_valid", int'(bus.sad_valid), 0);
    chk("rst_sad_value", int'(bus.sad_value), 0);
    chk("rst_search_done", int'(bus.search_done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_in_ready", int'(bus.in_ready), 0);

    // identical rows: SAD 0 at (5,3)
    do_start();
    obs_q.delete();
    fill_word(32'h10203040, 32'h10203040);
    send_cand(5, 3, 1'b1, 0, ROWS);
    wait_idle();
    chk_obs("zero_sad", 0, 0);
    chk("zero_min_sad", int'(bus.min_sad), 0);
    chk("zero_min_x", int'(bus.min_x), 5);
    chk("zero_min_y", int'(bus.min_y), 3);

    // full-scale difference both ways
    do_start();
    obs_q.delete();
    fill_word(32'hFFFFFFFF, 32'h00000000);
    send_cand(7, 9, 1'b1, 0, ROWS);
    wait_idle();
    chk_obs("max_sad_fw", 0, 4080);
    do_start();
    obs_q.delete();
    fill_word(32'h00000000, 32'hFFFFFFFF);
    send_cand(8, 10, 1'b1, 0, ROWS);
    wait_idle();
    chk_obs("max_sad_wf", 0, 4080);
    chk("max_min_sad", int'(bus.min_sad), 4080);

    // back-to-back, then with bubbles between every row
    three_cands(0);
    three_cands(2);

    // reset after row 1 of a candidate, then a clean SAD-7 search
    do_start();
    fill_rand();
    send_cand(9, 9, 1'b0, 0, 2);
    do_reset();
    do_start();
    obs_q.delete();
    clear_px(); cf[3][3] = 10; cw[3][3] = 3;
    send_cand(4, 4, 1'b1, 0, ROWS);
    wait_idle();
    chk("abort_count", obs_q.size(), 1);
    chk_obs("abort_sad", 0, 7);
    chk("abort_min_sad", int'(bus.min_sad), 7);
    chk("abort_min_x", int'(bus.min_x), 4);

    // randomized searches
    for (int s = 0; s < 12; s++) begin
      int n;
      n = int'($urandom_range(1, 5));
      do_start();
      for (int c = 0; c < n; c++) begin
        fill_rand();
        if ($urandom_range(0, 3) == 0) fill_word(32'h11223344, 32'h11223344);
        send_cand(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  (c == n - 1), int'($urandom_range(0, 2)), ROWS);
      end
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sad_search_engine.md
Name: sad_search_engine

Overview:
- Parametrised pipelined sum-of-absolute-differences (SAD) engine for block-match motion search, fed row vectors from the memory stage.
- Computes a full-block SAD per candidate position, streams each result out, and tracks the running minimum SAD and its (X,Y) over one search.
- Generalises the fixed two-stage SAD/min-tracking path to configurable pixel width, lane count and block height, and adds a start/done search handshake.

Parameters:
PIX_W, 8, bits per pixel (unsigned)
LANES, 4, pixels per row vector
ROWS, 4, rows per candidate block (>=1)
COORD_W, 6, width of X/Y coordinates
SAD_W, PIX_W+clog2(LANES*ROWS), localparam, SAD/accumulator width (12 at defaults); no overflow possible

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle pulse; begins a search (honoured in IDLE only)
InValid  in  1  input beat valid
InReady  out  1  engine accepts beat (high only in RUN)
FrameVec  in  LANES*PIX_W  current-frame row; lane i at [i*PIX_W +: PIX_W]
WinVec  in  LANES*PIX_W  reference-window row, same packing
InX  in  COORD_W  candidate X, sampled on row-0 beat
InY  in  COORD_W  candidate Y, sampled on row-0 beat
InLastCand  in  1  beat belongs to final candidate of search
SadValid  out  1  one-cycle pulse: candidate SAD complete
SadValue  out  SAD_W  candidate SAD
SadX, SadY  out  COORD_W  candidate coordinates
MinSad  out  SAD_W  running minimum SAD
MinX, MinY  out  COORD_W  coordinates of MinSad
MinValid  out  1  at least one candidate compared this search
SearchDone  out  1  one-cycle pulse at end of search
Busy  out  1  state != IDLE

Behaviour:
- Reset (async): FSM=IDLE; row counter=0; accumulator=0; all pipeline valids=0; SadValid=SearchDone=MinValid=0; SadValue=SadX=SadY=0; MinSad=all ones; MinX=MinY=0; InReady=0; Busy=0.
- FSM: IDLE -Start-> RUN (same edge: MinSad=all ones, MinX/MinY=0, MinValid=0, row counter=0, accumulator=0). RUN: accepts a beat on each edge with InValid&InReady. Accepted beat with row counter==ROWS-1 and InLastCand=1 -> DRAIN (InReady low). DRAIN: 3-cycle counter, then -> DONE. DONE: SearchDone=1 for one cycle -> IDLE.
- Start outside IDLE ignored. InValid outside RUN ignored.
- Row counter: increments per accepted beat; wraps ROWS-1 -> 0. Holds on bubbles (InValid=0); bubbles do not alter results.
- Pipeline, beat accepted at edge k:
  - edge k: stage 1 registers per-lane |FrameVec_i - WinVec_i| (PIX_W bits, unsigned), row index, last-row flag, and coords if row 0.
  - edge k+1: stage 2 sums lanes into accumulator. Row 0 loads the sum (no stale carry-over); other rows add.
  - edge k+2, last row only: SadValid=1, SadValue=final sum, SadX/SadY=stored coords.
  - edge k+3: compare. If !MinValid or SadValue < MinSad (strict), load MinSad/MinX/MinY; MinValid=1. Ties keep the earlier candidate.
- Back-to-back candidates at full rate: no stall. Stage-2 row-0 load separates candidates.
- DRAIN length guarantees the final Min update is visible on the SearchDone cycle.
- Min* outputs hold after SearchDone until the next Start.
- A short search (InLastCand never seen) stays in RUN indefinitely. Only Reset recovers it.
- Reset mid-candidate: all partial state discarded. The next search after Start is unaffected.

Test Plan:
- Reset with defaults -> InReady=0, Busy=0, MinSad=0xFFF, MinX=MinY=0, all pulses 0; Reset released with Start=0 -> state stays IDLE.
- Start; one candidate (X=5,Y=3), 4 rows FrameVec=WinVec=0x10203040, InLastCand=1 -> SadValid 2 cycles after row-3 beat, SadValue=0, (5,3); SearchDone next cycle after DRAIN with MinSad=0, MinX=5, MinY=3.
- One candidate, all 16 frame pixels 0xFF, window 0x00 -> SadValue=0xFF0 (4080), no overflow; reversed operands -> also 0xFF0.
- Three back-to-back candidates at (1,0),(2,0),(3,0) with SADs 40,12,12, no bubbles -> SadValid pulses 4 cycles apart; final MinSad=12, MinX=2 (tie keeps first).
- Same as the previous scenario with InValid low 2 cycles between every row -> identical SadValue sequence and Min result.
- Reset pulsed after row 1 of a candidate, then Start and a clean candidate with SAD 7 -> SadValue=7, MinSad=7; no residue from the aborted candidate.
